// File: rtl/servo_pkg.sv
// Scaling defaults and FSM encoding shared by the servo pulse generator and decoder,
// so both ends agree on offset/step scaling.
package servo_pkg;

  localparam int unsigned SERVO_OFFSET    = 10000;
  localparam int unsigned SERVO_STEP      = 40;
  localparam int unsigned SERVO_MIN_WIDTH = 5000;
  localparam int unsigned SERVO_MAX_WIDTH = 25000;
  localparam int unsigned SERVO_TIMEOUT   = 250000;

  typedef enum logic [1:0] {
    WAIT_LOW  = 2'd0,
    WAIT_RISE = 2'd1,
    MEASURE   = 2'd2
  } servo_dec_state_e;

endpackage

// File: rtl/servo_in_sync.sv
// Two-flop synchronizer for the servo input, plus a history flop for edge detection.
// Resets to 1 so that a line already high at reset release is not taken as a rising edge.
module servo_in_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  always_comb begin
    s1_d = async_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign level  = s2_q;
  assign rise_c = s2_q & ~s3_q;
  assign fall_c = ~s2_q & s3_q;

endmodule

// File: rtl/servo_pulse_decoder.sv
// Measures the high time of an RC-servo pulse and converts it to an 8-bit position code
// without a divider. It also flags out-of-range pulses and loss of signal.
module servo_pulse_decoder
  import servo_pkg::*;
#(
  parameter int unsigned OFFSET    = SERVO_OFFSET,
  parameter int unsigned STEP      = SERVO_STEP,
  parameter int unsigned MIN_WIDTH = SERVO_MIN_WIDTH,
  parameter int unsigned MAX_WIDTH = SERVO_MAX_WIDTH,
  parameter int unsigned TIMEOUT   = SERVO_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       pwm_in,
  output logic [7:0] pos_out,
  output logic       pos_valid,
  output logic       sample_stb,
  output logic       err_stb,
  output logic       timeout
);

  localparam int unsigned WIDTH_W = $clog2(MAX_WIDTH + 2);
  localparam int unsigned TO_W    = $clog2(TIMEOUT + 1);
  localparam int unsigned STEP_W  = $clog2(STEP);

  localparam logic [WIDTH_W-1:0] OFFSET_C    = WIDTH_W'(OFFSET);
  localparam logic [WIDTH_W-1:0] MIN_C       = WIDTH_W'(MIN_WIDTH);
  localparam logic [WIDTH_W-1:0] MAX_C       = WIDTH_W'(MAX_WIDTH);
  localparam logic [TO_W-1:0]    TIMEOUT_C   = TO_W'(TIMEOUT);
  localparam logic [STEP_W-1:0]  STEP_LAST_C = STEP_W'(STEP - 1);

  logic level, rise_c, fall_c;

  servo_in_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (pwm_in),
    .level    (level),
    .rise_c   (rise_c),
    .fall_c   (fall_c)
  );

  servo_dec_state_e   state_q, state_d;
  logic [WIDTH_W-1:0] width_cnt_q, width_cnt_d;
  logic [STEP_W-1:0]  step_cnt_q, step_cnt_d;
  logic [7:0]         pos_acc_q, pos_acc_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [7:0]         pos_out_q, pos_out_d;
  logic               pos_valid_q, pos_valid_d;
  logic               sample_stb_q, sample_stb_d;
  logic               err_stb_q, err_stb_d;
  logic               timeout_q, timeout_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WAIT_LOW;
      width_cnt_q  <= '0;
      step_cnt_q   <= '0;
      pos_acc_q    <= '0;
      to_cnt_q     <= '0;
      pos_out_q    <= '0;
      pos_valid_q  <= 1'b0;
      sample_stb_q <= 1'b0;
      err_stb_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      width_cnt_q  <= width_cnt_d;
      step_cnt_q   <= step_cnt_d;
      pos_acc_q    <= pos_acc_d;
      to_cnt_q     <= to_cnt_d;
      pos_out_q    <= pos_out_d;
      pos_valid_q  <= pos_valid_d;
      sample_stb_q <= sample_stb_d;
      err_stb_q    <= err_stb_d;
      timeout_q    <= timeout_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    width_cnt_d  = width_cnt_q;
    step_cnt_d   = step_cnt_q;
    pos_acc_d    = pos_acc_q;
    to_cnt_d     = to_cnt_q;
    pos_out_d    = pos_out_q;
    pos_valid_d  = pos_valid_q;
    timeout_d    = timeout_q;
    sample_stb_d = 1'b0;
    err_stb_d    = 1'b0;

    if (!ena) begin
      state_d     = WAIT_LOW;
      width_cnt_d = '0;
      step_cnt_d  = '0;
      pos_acc_d   = '0;
      to_cnt_d    = '0;
    end else begin
      if (rise_c) begin
        to_cnt_d = '0;
      end else if (to_cnt_q != TIMEOUT_C) begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
      if (to_cnt_q == TIMEOUT_C) begin
        timeout_d   = 1'b1;
        pos_valid_d = 1'b0;
      end

      case (state_q)
        WAIT_LOW: begin
          if (!level) state_d = WAIT_RISE;
        end
        WAIT_RISE: begin
          if (rise_c) begin
            state_d     = MEASURE;
            width_cnt_d = WIDTH_W'(1);
            step_cnt_d  = '0;
            pos_acc_d   = '0;
          end
        end
        MEASURE: begin
          if (fall_c) begin
            state_d = WAIT_RISE;
            if (width_cnt_q >= MIN_C && width_cnt_q <= MAX_C) begin
              pos_out_d    = pos_acc_q;
              pos_valid_d  = 1'b1;
              timeout_d    = 1'b0;
              sample_stb_d = 1'b1;
            end else begin
              err_stb_d = 1'b1;
            end
          end else if (width_cnt_q == MAX_C) begin
            // Stuck-high or over-long pulse: reject now rather than wait for a fall.
            state_d     = WAIT_LOW;
            width_cnt_d = MAX_C + WIDTH_W'(1);
            err_stb_d   = 1'b1;
          end else begin
            width_cnt_d = width_cnt_q + WIDTH_W'(1);
            // Each high cycle past OFFSET is one step tick; STEP ticks add one position LSB.
            if (width_cnt_q >= OFFSET_C) begin
              if (step_cnt_q == STEP_LAST_C) begin
                step_cnt_d = '0;
                if (pos_acc_q != 8'hFF) pos_acc_d = pos_acc_q + 8'd1;
              end else begin
                step_cnt_d = step_cnt_q + STEP_W'(1);
              end
            end
          end
        end
        default: state_d = WAIT_LOW;
      endcase
    end
  end

  assign pos_out    = pos_out_q;
  assign pos_valid  = pos_valid_q;
  assign sample_stb = sample_stb_q;
  assign err_stb    = err_stb_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Directed bench for servo_pulse_decoder; scaling is divided by ten so the timeout
// scenario stays short (OFFSET 1000, STEP 4, MIN 500, MAX 2500, TIMEOUT 25000).
module tb_servo_pulse_decoder;

  localparam int unsigned P_OFFSET  = 1000;
  localparam int unsigned P_STEP    = 4;
  localparam int unsigned P_MIN     = 500;
  localparam int unsigned P_MAX     = 2500;
  localparam int unsigned P_TIMEOUT = 25000;
  localparam int          GAP       = 20;

  logic       clk, rst_n, ena, pwm_in;
  logic [7:0] pos_out;
  logic       pos_valid, sample_stb, err_stb, timeout;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int sample_cnt = 0, err_cnt = 0, both_cnt = 0;
  int last_sample_cyc = 0, last_err_cyc = 0, to_rise_cyc = 0;
  int hi_cyc = 0, lo_cyc = 0;
  logic prev_timeout = 1'b0;

  servo_pulse_decoder #(
    .OFFSET    (P_OFFSET),
    .STEP      (P_STEP),
    .MIN_WIDTH (P_MIN),
    .MAX_WIDTH (P_MAX),
    .TIMEOUT   (P_TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .pwm_in     (pwm_in),
    .pos_out    (pos_out),
    .pos_valid  (pos_valid),
    .sample_stb (sample_stb),
    .err_stb    (err_stb),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe and timeout bookkeeping, sampled mid-cycle.
  always @(negedge clk) begin
    if (sample_stb) begin
      sample_cnt++;
      last_sample_cyc = cyc;
    end
    if (err_stb) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
    if (sample_stb && err_stb) both_cnt++;
    if (timeout && !prev_timeout) to_rise_cyc = cyc;
    prev_timeout = timeout;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse(input int n);
    @(negedge clk);
    pwm_in = 1'b1;
    hi_cyc = cyc;
    repeat (n) @(negedge clk);
    pwm_in = 1'b0;
    lo_cyc = cyc;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic decode_ok(input string tag, input int n, input int exp_pos);
    int s0, e0;
    s0 = sample_cnt;
    e0 = err_cnt;
    pulse(n);
    check({tag, "_samples"}, 32'(sample_cnt - s0), 32'd1);
    check({tag, "_errs"}, 32'(err_cnt - e0), 32'd0);
    check({tag, "_latency"}, 32'(last_sample_cyc - lo_cyc), 32'd3);
    check({tag, "_pos"}, 32'(pos_out), 32'(exp_pos));
    check({tag, "_valid"}, 32'(pos_valid), 32'd1);
    check({tag, "_timeout"}, 32'(timeout), 32'd0);
  endtask

  task automatic reject(input string tag, input int n, input int exp_pos, input logic early);
    int s0, e0;
    s0 = sample_cnt;
    e0 = err_cnt;
    pulse(n);
    check({tag, "_samples"}, 32'(sample_cnt - s0), 32'd0);
    check({tag, "_errs"}, 32'(err_cnt - e0), 32'd1);
    if (early) check({tag, "_err_time"}, 32'(last_err_cyc - hi_cyc), 32'(P_MAX + 3));
    else       check({tag, "_err_time"}, 32'(last_err_cyc - lo_cyc), 32'd3);
    check({tag, "_pos"}, 32'(pos_out), 32'(exp_pos));
    check({tag, "_valid"}, 32'(pos_valid), 32'd1);
  endtask

  initial begin
    int s0, e0;
    rst_n  = 1'b0;
    ena    = 1'b1;
    pwm_in = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_pos", 32'(pos_out), 32'd0);
    check("rst_valid", 32'(pos_valid), 32'd0);
    check("rst_sample", 32'(sample_stb), 32'd0);
    check("rst_err", 32'(err_stb), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    decode_ok("p1512", 1512, 128);
    reject("p499", 499, 128, 1'b0);
    reject("p2501", 2501, 128, 1'b1);
    decode_ok("p1000", 1000, 0);
    decode_ok("p1003", 1003, 0);
    decode_ok("p1004", 1004, 1);
    decode_ok("p2500", 2500, 255);

    // Hold the line low long enough to lose the signal.
    repeat (P_TIMEOUT + 10) @(negedge clk);
    check("to_level", 32'(timeout), 32'd1);
    check("to_valid", 32'(pos_valid), 32'd0);
    check("to_pos_hold", 32'(pos_out), 32'd255);
    check("to_time", 32'(to_rise_cyc - hi_cyc), 32'(P_TIMEOUT + 4));
    decode_ok("p1200", 1200, 50);

    // Reset released while the line is high mid-pulse.
    s0 = sample_cnt;
    e0 = err_cnt;
    @(negedge clk);
    pwm_in = 1'b1;
    repeat (300) @(negedge clk);
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (800) @(negedge clk);
    pwm_in = 1'b0;
    repeat (GAP) @(negedge clk);
    check("rstmid_samples", 32'(sample_cnt - s0), 32'd0);
    check("rstmid_errs", 32'(err_cnt - e0), 32'd0);
    check("rstmid_pos", 32'(pos_out), 32'd0);
    check("rstmid_valid", 32'(pos_valid), 32'd0);
    decode_ok("rstmid_next", 1512, 128);

    // Enable dropped and restored while the line is still high.
    s0 = sample_cnt;
    e0 = err_cnt;
    @(negedge clk);
    pwm_in = 1'b1;
    repeat (400) @(negedge clk);
    ena = 1'b0;
    repeat (100) @(negedge clk);
    ena = 1'b1;
    repeat (700) @(negedge clk);
    pwm_in = 1'b0;
    repeat (GAP) @(negedge clk);
    check("ena_samples", 32'(sample_cnt - s0), 32'd0);
    check("ena_errs", 32'(err_cnt - e0), 32'd0);
    check("ena_pos_hold", 32'(pos_out), 32'd128);
    check("ena_valid_hold", 32'(pos_valid), 32'd1);
    decode_ok("ena_next", 1004, 1);

    check("never_both_strobes", 32'(both_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
